// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports, one write port, write-to-read bypass,
// and a per-register busy scoreboard that tracks pending writebacks for the issue logic.
module regfile_scoreboard #(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_ready,
  input  logic                 flush
);

  logic [WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic             wr_en;
  logic             iss_hit_wb;
  logic             iss_accept;

  // Writes to r0 are dropped everywhere, so they never bypass or clear anything.
  assign wr_en = we && (waddr != '0);

  assign iss_hit_wb = wr_en && (waddr == iss_rd);
  assign iss_ready  = (iss_rd == '0) || !busy[iss_rd] || iss_hit_wb;
  assign iss_accept = iss_valid && iss_ready && (iss_rd != '0);

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra  = raddr[i*AW +: AW];
    assign hit = wr_en && (waddr == ra);

    assign rdata[i*WIDTH +: WIDTH] = (ra == '0) ? '0 :
                                     hit        ? wdata :
                                                  rf[ra];
    // A source being written this cycle is covered by the bypass, so it is not a hazard.
    assign rbusy[i] = busy[ra] && !hit;
  end

  // Clear by writeback, then flush, then set by issue: issue wins over both.
  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[waddr] = 1'b0;
    end
    if (flush) begin
      busy_next = '0;
    end
    if (iss_accept) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        rf[r] <= '0;
      end
    end else if (wr_en) begin
      rf[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: vector table through a scoreboard queue on a 2-port instance,
// plus a hand sequence on a 4-port, 16-register instance for the all-ports bypass case.
module tb_regfile_scoreboard;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int AW4   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [2*AW-1:0]      raddr = '0;
  logic [2*WIDTH-1:0]   rdata;
  logic [1:0]           rbusy;
  logic                 we = 1'b0;
  logic [AW-1:0]        waddr = '0;
  logic [WIDTH-1:0]     wdata = '0;
  logic                 iss_valid = 1'b0;
  logic [AW-1:0]        iss_rd = '0;
  logic                 iss_ready;
  logic                 flush = 1'b0;

  logic [4*AW4-1:0]     raddr4 = '0;
  logic [4*WIDTH-1:0]   rdata4;
  logic [3:0]           rbusy4;
  logic                 we4 = 1'b0;
  logic [AW4-1:0]       waddr4 = '0;
  logic [WIDTH-1:0]     wdata4 = '0;
  logic                 iss_valid4 = 1'b0;
  logic [AW4-1:0]       iss_rd4 = '0;
  logic                 iss_ready4;
  logic                 flush4 = 1'b0;

  regfile_scoreboard #(.WIDTH(WIDTH), .NREG(32), .NRD(2)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready), .flush(flush)
  );

  regfile_scoreboard #(.WIDTH(WIDTH), .NREG(16), .NRD(4)) dut4 (
    .clk(clk), .rst(rst), .raddr(raddr4), .rdata(rdata4), .rbusy(rbusy4),
    .we(we4), .waddr(waddr4), .wdata(wdata4),
    .iss_valid(iss_valid4), .iss_rd(iss_rd4), .iss_ready(iss_ready4), .flush(flush4)
  );

  typedef struct {
    logic             rst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             iv;
    logic [AW-1:0]    ird;
    logic             fl;
    logic [AW-1:0]    ra0;
    logic [AW-1:0]    ra1;
    logic             chk;
    logic [WIDTH-1:0] exp_d0;
    logic [WIDTH-1:0] exp_d1;
    logic [1:0]       exp_b;
    logic             exp_rdy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic w, int wa, logic [WIDTH-1:0] wd,
                              logic iv, int ird, logic fl, int ra0, int ra1, logic chk,
                              logic [WIDTH-1:0] d0, logic [WIDTH-1:0] d1,
                              logic [1:0] b, logic rdy);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = AW'(wa); v.wdata = wd;
    v.iv = iv; v.ird = AW'(ird); v.fl = fl;
    v.ra0 = AW'(ra0); v.ra1 = AW'(ra1); v.chk = chk;
    v.exp_d0 = d0; v.exp_d1 = d1; v.exp_b = b; v.exp_rdy = rdy;
    return v;
  endfunction

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    we        = v.we;
    waddr     = v.waddr;
    wdata     = v.wdata;
    iss_valid = v.iv;
    iss_rd    = v.ird;
    flush     = v.fl;
    raddr     = {v.ra1, v.ra0};
    if (v.chk) sb_q.push_back(v);
  endtask

  task automatic check_output(input int idx);
    vec_t e;
    #1;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    compare($sformatf("v%0d rdata0", idx), 128'(rdata[WIDTH-1:0]), 128'(e.exp_d0));
    compare($sformatf("v%0d rdata1", idx), 128'(rdata[2*WIDTH-1:WIDTH]), 128'(e.exp_d1));
    compare($sformatf("v%0d rbusy", idx), 128'(rbusy), 128'(e.exp_b));
    compare($sformatf("v%0d iss_ready", idx), 128'(iss_ready), 128'(e.exp_rdy));
  endtask

  initial begin
    //                rst we wa wdata          iv ird fl ra0 ra1 chk d0            d1            b      rdy
    vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF,   0, 0,  0, 5,  0,  0, 0,            0,            2'b00, 1));
    vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF,   0, 0,  0, 5,  0,  0, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 5,  0, 5,  0,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 1, 3, 32'h12345678,   0, 0,  0, 3,  0,  1, 32'h12345678, 0,            2'b00, 1));
    vecs.push_back(mk(0, 1, 0, 32'hFFFFFFFF,   0, 0,  0, 3,  0,  1, 32'h12345678, 0,            2'b00, 1));
    vecs.push_back(mk(0, 1, 7, 32'h11,         0, 0,  0, 7,  3,  1, 32'h11,       32'h12345678, 2'b00, 1));
    vecs.push_back(mk(0, 1, 7, 32'h22,         0, 0,  0, 7,  7,  1, 32'h22,       32'h22,       2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 0,  0, 7,  0,  1, 32'h22,       0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              1, 9,  0, 9,  0,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 9,  0, 9,  9,  1, 0,            0,            2'b11, 0));
    vecs.push_back(mk(0, 0, 0, 0,              1, 9,  0, 9,  0,  1, 0,            0,            2'b01, 0));
    vecs.push_back(mk(0, 1, 9, 32'h55,         0, 9,  0, 9,  9,  1, 32'h55,       32'h55,       2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 9,  0, 9,  0,  1, 32'h55,       0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              1, 4,  0, 4,  0,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 1, 4, 32'hAB,         1, 4,  0, 4,  4,  1, 32'hAB,       32'hAB,       2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 4,  0, 4,  0,  1, 32'hAB,       0,            2'b01, 0));
    vecs.push_back(mk(0, 0, 0, 0,              1, 6,  1, 4,  6,  1, 32'hAB,       0,            2'b01, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 6,  0, 4,  6,  1, 32'hAB,       0,            2'b10, 0));
    vecs.push_back(mk(0, 0, 0, 0,              1, 6,  1, 6,  6,  1, 0,            0,            2'b11, 0));
    vecs.push_back(mk(0, 0, 0, 0,              0, 6,  0, 6,  4,  1, 0,            32'hAB,       2'b00, 1));
    vecs.push_back(mk(0, 1, 10, 32'hCAFE,      0, 0,  1, 10, 0,  1, 32'hCAFE,     0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 0,  0, 10, 0,  1, 32'hCAFE,     0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              1, 0,  0, 0,  0,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 0,  0, 0,  0,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              1, 12, 0, 12, 0,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 12, 0, 12, 3,  1, 0,            32'h12345678, 2'b01, 0));
    vecs.push_back(mk(1, 1, 12, 32'h77,        0, 12, 0, 12, 3,  0, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 12, 0, 12, 3,  1, 0,            0,            2'b00, 1));
    vecs.push_back(mk(0, 1, 12, 32'h99,        0, 12, 0, 12, 0,  1, 32'h99,       0,            2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0,              0, 12, 0, 12, 12, 1, 32'h99,       32'h99,       2'b00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(i);
    end

    // 4-port instance, reset by the table's second reset entry.
    @(negedge clk);
    we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
    iss_valid4 = 1'b1; iss_rd4 = 4'd15;
    raddr4 = {4'd15, 4'd15, 4'd15, 4'd15};
    #1;
    compare("p4 issue ready", 128'(iss_ready4), 128'(1'b1));
    compare("p4 rbusy before issue", 128'(rbusy4), 128'(4'b0000));

    @(negedge clk);
    iss_valid4 = 1'b0;
    #1;
    compare("p4 rbusy pending", 128'(rbusy4), 128'(4'b1111));
    compare("p4 ready pending", 128'(iss_ready4), 128'(1'b0));

    @(negedge clk);
    we4 = 1'b1; waddr4 = 4'd15; wdata4 = 32'hA5A5A5A5;
    #1;
    compare("p4 bypass rdata", 128'(rdata4), {4{32'hA5A5A5A5}});
    compare("p4 bypass rbusy", 128'(rbusy4), 128'(4'b0000));
    compare("p4 bypass ready", 128'(iss_ready4), 128'(1'b1));

    @(negedge clk);
    we4 = 1'b0;
    #1;
    compare("p4 stored rdata", 128'(rdata4), {4{32'hA5A5A5A5}});
    compare("p4 cleared rbusy", 128'(rbusy4), 128'(4'b0000));

    @(negedge clk);
    raddr4 = {4'd15, 4'd0, 4'd15, 4'd3};
    #1;
    compare("p4 mixed rdata", 128'(rdata4), {32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0});

    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
